// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single shared memory port.
// Data normally wins; a fetch that has waited STARVE_LIMIT cycles takes priority.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [2:0]  if_op,
    input  logic [31:0] if_addr,
    input  logic [31:0] if_wdata,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_fault,

    input  logic        d_req,
    input  logic [2:0]  d_op,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_fault,

    output logic        mem_req,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_fault,

    output logic        busy,
    output logic        owner,
    output logic        timeout
);

    localparam int unsigned WaitW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CntW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] StarveMax  = WaitW'(STARVE_LIMIT);
    localparam logic [CntW-1:0]  TimeoutMax = CntW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e            state_q, state_d;
    logic [WaitW-1:0]  fetch_wait_q;
    logic [CntW-1:0]   cnt_q;
    logic              owner_q;
    logic [2:0]        op_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       if_rdata_q, d_rdata_q;
    logic              if_fault_q, d_fault_q;

    logic              fetch_wins;
    logic              resp_load;
    logic [31:0]       rdata_new;
    logic              fault_new;

    assign fetch_wins = if_req && (!d_req || (fetch_wait_q >= StarveMax));

    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        mem_req = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Grants are suppressed while reset is asserted so no grant is ever lost.
                if (!reset && (if_req || d_req)) begin
                    if (fetch_wins) begin
                        if_gnt = 1'b1;
                    end else begin
                        d_gnt = 1'b1;
                    end
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == TimeoutMax) begin
                    timeout = 1'b1;
                    state_d = StResp;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign resp_load = (mem_req && mem_ack) || timeout;
    assign rdata_new = timeout ? 32'h0 : mem_rdata;
    assign fault_new = timeout ? 1'b1 : mem_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            fetch_wait_q <= '0;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            if_fault_q   <= 1'b0;
            d_rdata_q    <= '0;
            d_fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (if_gnt || d_gnt) begin
                owner_q <= d_gnt;
                op_q    <= d_gnt ? d_op    : if_op;
                addr_q  <= d_gnt ? d_addr  : if_addr;
                wdata_q <= d_gnt ? d_wdata : if_wdata;
            end

            if (state_q == StBusy) begin
                cnt_q <= cnt_q + CntW'(1);
            end else begin
                cnt_q <= '0;
            end

            if (!if_req || if_gnt) begin
                fetch_wait_q <= '0;
            end else if (fetch_wait_q < StarveMax) begin
                fetch_wait_q <= fetch_wait_q + WaitW'(1);
            end

            // Load the owner's response registers on the edge into RESP so they are
            // valid during the rvalid cycle and hold until that port's next response.
            if (resp_load) begin
                if (owner_q) begin
                    d_rdata_q <= rdata_new;
                    d_fault_q <= fault_new;
                end else begin
                    if_rdata_q <= rdata_new;
                    if_fault_q <= fault_new;
                end
            end
        end
    end

    assign if_rvalid = (state_q == StResp) && !owner_q;
    assign d_rvalid  = (state_q == StResp) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign if_fault  = if_fault_q;
    assign d_rdata   = d_rdata_q;
    assign d_fault   = d_fault_q;
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != StIdle);
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them on each rvalid.
module tb_mem_port_arbiter;

    localparam logic [31:0] Mix = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req;
    logic [2:0]  if_op, d_op;
    logic [31:0] if_addr, if_wdata, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, if_fault, d_gnt, d_rvalid, d_fault;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_fault = 1'b0;
    logic        busy, owner, timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (255)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_op    (if_op),
        .if_addr  (if_addr),
        .if_wdata (if_wdata),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_fault (if_fault),
        .d_req    (d_req),
        .d_op     (d_op),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_fault  (d_fault),
        .mem_req  (mem_req),
        .mem_op   (mem_op),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .mem_fault(mem_fault),
        .busy     (busy),
        .owner    (owner),
        .timeout  (timeout)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        fault;
    } resp_t;

    resp_t exp_q[$];

    bit          ack_en    = 1'b0;
    bit          force_ack = 1'b0;
    bit          fault_cfg = 1'b0;
    bit          ovr_en    = 1'b0;
    logic [31:0] ovr_data  = 32'h0;
    bit          mon_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks in the same cycle mem_req is seen; data derived from address.
    always @(negedge clk) begin
        mem_ack   = force_ack || (ack_en && (mem_req === 1'b1));
        mem_rdata = ovr_en ? ovr_data : (mem_addr ^ Mix);
        mem_fault = fault_cfg;
    end

    always @(negedge clk) begin
        if (mon_en && ((if_rvalid === 1'b1) || (d_rvalid === 1'b1))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", {if_rvalid, d_rvalid}, 0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("resp_single", if_rvalid & d_rvalid, 0);
                check("resp_port", d_rvalid, e.port);
                check("resp_rdata", e.port ? d_rdata : if_rdata, e.rdata);
                check("resp_fault", e.port ? d_fault : if_fault, e.fault);
            end
        end
    end

    task automatic issue(input bit port, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bit ok;
        if (port) begin
            d_req = 1'b1; d_op = op; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_op = op; if_addr = addr; if_wdata = wdata;
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port ? d_gnt : if_gnt) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("gnt_seen", ok, 1);
        check("gnt_other", port ? if_gnt : d_gnt, 0);
        @(posedge clk);
        #1;
        if (port) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_seq [8];
        int cnt;
        bit seen;

        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b1;
        if_req = 1'b1; if_op = 3'b0; if_addr = 32'h0; if_wdata = 32'h0;
        d_req  = 1'b1; d_op  = 3'b0; d_addr  = 32'h0; d_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_gnt", if_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_timeout", timeout, 0);
        check("rst_if_rvalid", if_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_if_fault", if_fault, 0);
        check("rst_d_fault", d_fault, 0);
        @(posedge clk);
        #1;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        mon_en = 1'b1;

        // Single fetch with minimum latency.
        ack_en = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        @(negedge clk);
        check("f_mem_req", mem_req, 1);
        check("f_mem_addr", mem_addr, 32'h100);
        check("f_mem_op", mem_op, 3'b010);
        check("f_owner", owner, 0);
        check("f_busy", busy, 1);
        @(negedge clk);
        check("f_if_rvalid", if_rvalid, 1);
        check("f_d_rvalid", d_rvalid, 0);
        @(negedge clk);
        check("f_idle", busy, 0);
        ovr_en = 1'b0;

        // Stray ack in IDLE.
        @(posedge clk);
        #1;
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_mem_req", mem_req, 0);
        check("stray_hold_rdata", if_rdata, 32'hDEAD_BEEF);
        force_ack = 1'b0;

        // Memory fault on a data access.
        @(posedge clk);
        #1;
        fault_cfg = 1'b1;
        exp_q.push_back('{1'b1, 32'h300 ^ Mix, 1'b1});
        issue(1'b1, 3'b001, 32'h300, 32'h55);
        repeat (3) @(posedge clk);
        #1;
        fault_cfg = 1'b0;

        // Contention with starvation relief.
        if_req = 1'b1; if_op = 3'b010; if_addr = 32'h200; if_wdata = 32'h0;
        d_req  = 1'b1; d_op  = 3'b001; d_addr  = 32'h300; d_wdata = 32'h77;
        for (int k = 0; k < 8; k++) begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if ((if_gnt === 1'b1) || (d_gnt === 1'b1)) begin
                    got = 1'b1;
                    break;
                end
            end
            check("cont_gnt_seen", got, 1);
            check("cont_gnt_excl", if_gnt & d_gnt, 0);
            check("cont_order", d_gnt, exp_seq[k]);
            if (d_gnt === 1'b1) exp_q.push_back('{1'b1, 32'h300 ^ Mix, 1'b0});
            else                exp_q.push_back('{1'b0, 32'h200 ^ Mix, 1'b0});
        end
        @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Timeout with no ack.
        ack_en = 1'b0;
        exp_q.push_back('{1'b1, 32'h0, 1'b1});
        issue(1'b1, 3'b001, 32'h400, 32'h1234);
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                seen = 1'b1;
                check("to_mem_req_low", mem_req, 0);
                break;
            end
            if (mem_req === 1'b1) cnt++;
        end
        check("to_seen", seen, 1);
        check("to_req_cycles", cnt, 255);
        @(negedge clk);
        check("to_pulse_end", timeout, 0);
        check("to_d_rvalid", d_rvalid, 1);
        check("to_if_rvalid", if_rvalid, 0);
        @(posedge clk);
        #1;

        // Reset during the third BUSY cycle.
        issue(1'b1, 3'b001, 32'h500, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rb_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rb_mem_req", mem_req, 0);
        check("rb_busy", busy, 0);
        check("rb_if_rdata", if_rdata, 0);
        repeat (3) @(negedge clk);
        check("rb_no_rvalid", {if_rvalid, d_rvalid}, 0);
        @(posedge clk);
        #1;
        ack_en = 1'b1;
        exp_q.push_back('{1'b1, 32'h500 ^ Mix, 1'b0});
        issue(1'b1, 3'b001, 32'h500, 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk);

        check("queue_empty", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
